// File: rtl/approx_mul_err_eval.sv
// Sweeps all 65536 operand pairs through an 8x8 approximate multiplier and
// accumulates error statistics of its products against the exact product.
module approx_mul_err_eval #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_vld,
  input  logic [15:0] mul_prod,
  output logic [16:0] err_cnt,
  output logic [31:0] sum_ed,
  output logic [15:0] max_ed,
  output logic [7:0]  max_a,
  output logic [7:0]  max_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        vld;
    logic [15:0] pair;
    logic [15:0] exact;
  } tap_t;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [16:0] err_cnt_q, err_cnt_d;
  logic [31:0] sum_ed_q, sum_ed_d;
  logic [15:0] max_ed_q, max_ed_d;
  logic [15:0] max_pair_q, max_pair_d;

  tap_t        issue_s;
  tap_t        acc_s;
  logic [15:0] ed_s;
  logic        acc_last_s;

  // Exact product of the pair currently on the multiplier inputs.
  always_comb begin
    issue_s.vld   = vld_q;
    issue_s.pair  = cnt_q;
    issue_s.exact = {8'd0, cnt_q[15:8]} * {8'd0, cnt_q[7:0]};
  end

  // Delay the exact product so it meets mul_prod in the same cycle.
  generate
    if (MUL_LAT == 32'd0) begin : g_nodly
      assign acc_s = issue_s;
    end else begin : g_dly
      tap_t dly_q [MUL_LAT];

      // Alignment shift register, flushed by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MUL_LAT; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= issue_s;
          for (int i = 1; i < MUL_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign acc_s = dly_q[MUL_LAT-1];
    end
  endgenerate

  assign ed_s       = (mul_prod >= acc_s.exact) ? (mul_prod - acc_s.exact)
                                                : (acc_s.exact - mul_prod);
  assign acc_last_s = acc_s.vld && (acc_s.pair == 16'hFFFF);

  // Next-state: accumulation first, so a start request can override with a clear.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vld_d      = vld_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    sum_ed_d   = sum_ed_q;
    max_ed_d   = max_ed_q;
    max_pair_d = max_pair_q;

    if (busy_q && acc_s.vld) begin
      if (ed_s != 16'd0) begin
        err_cnt_d = err_cnt_q + 17'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      sum_ed_d = sum_ed_q + {16'd0, ed_s};
      // Strict compare keeps the first pair on ties.
      if (ed_s > max_ed_q) begin
        max_ed_d   = ed_s;
        max_pair_d = acc_s.pair;
      end else begin
        max_ed_d   = max_ed_q;
        max_pair_d = max_pair_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SWEEP;
          cnt_d      = 16'd0;
          vld_d      = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_cnt_d  = 17'd0;
          sum_ed_d   = 32'd0;
          max_ed_d   = 16'd0;
          max_pair_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      SWEEP: begin
        if (cnt_q == 16'hFFFF) begin
          cnt_d = 16'd0;
          vld_d = 1'b0;
          if (acc_last_s) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DRAIN: begin
        if (acc_last_s) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= 17'd0;
      sum_ed_q   <= 32'd0;
      max_ed_q   <= 16'd0;
      max_pair_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      sum_ed_q   <= sum_ed_d;
      max_ed_q   <= max_ed_d;
      max_pair_q <= max_pair_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mul_a   = cnt_q[15:8];
  assign mul_b   = cnt_q[7:0];
  assign mul_vld = vld_q;
  assign err_cnt = err_cnt_q;
  assign sum_ed  = sum_ed_q;
  assign max_ed  = max_ed_q;
  assign max_a   = max_pair_q[15:8];
  assign max_b   = max_pair_q[7:0];

endmodule

// File: tb/tb_approx_mul_err_eval.sv
// Runs five evaluator instances in parallel, each against a different multiplier model.
module tb_approx_mul_err_eval;

  logic clk = 1'b0;
  logic rst, rs_rst, b0_exact;
  logic st_rs, st_b0, st_z, st_l2, st_rn;
  always #5 clk = ~clk;

  logic busy_rs, done_rs, vld_rs; logic [7:0] a_rs, b_rs, ma_rs, mb_rs;
  logic [15:0] prod_rs, max_rs; logic [16:0] err_rs; logic [31:0] sum_rs;
  logic busy_b0, done_b0, vld_b0; logic [7:0] a_b0, b_b0, ma_b0, mb_b0;
  logic [15:0] prod_b0, max_b0; logic [16:0] err_b0; logic [31:0] sum_b0;
  logic busy_z, done_z, vld_z; logic [7:0] a_z, b_z, ma_z, mb_z;
  logic [15:0] prod_z, max_z; logic [16:0] err_z; logic [31:0] sum_z;
  logic busy_l2, done_l2, vld_l2; logic [7:0] a_l2, b_l2, ma_l2, mb_l2;
  logic [15:0] prod_l2, max_l2, p2_1; logic [16:0] err_l2; logic [31:0] sum_l2;
  logic busy_rn, done_rn, vld_rn; logic [7:0] a_rn, b_rn, ma_rn, mb_rn;
  logic [15:0] prod_rn, max_rn; logic [16:0] err_rn; logic [31:0] sum_rn;

  logic [7:0] rn_am, rn_bm, rn_xm;
  int total = 0;
  int bad   = 0;
  longint exp_err, exp_sum, exp_max, exp_ma, exp_mb;

  function automatic logic [15:0] approx_rn(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a & rn_am} * {8'd0, b & rn_bm};
    return p ^ {8'd0, (a ^ b) & rn_xm};
  endfunction

  assign prod_rs = {8'd0, a_rs} * {8'd0, b_rs};
  assign prod_b0 = b0_exact ? ({8'd0, a_b0} * {8'd0, b_b0})
                            : (({8'd0, a_b0} * {8'd0, b_b0}) & 16'hFFFE);
  assign prod_z  = 16'd0;
  always @(posedge clk) begin
    p2_1    <= {8'd0, a_l2} * {8'd0, b_l2};
    prod_l2 <= p2_1;
    prod_rn <= approx_rn(a_rn, b_rn);
  end

  approx_mul_err_eval #(.MUL_LAT(0)) u_rs (.clk(clk), .rst(rst | rs_rst), .start(st_rs),
    .busy(busy_rs), .done(done_rs), .mul_a(a_rs), .mul_b(b_rs), .mul_vld(vld_rs),
    .mul_prod(prod_rs), .err_cnt(err_rs), .sum_ed(sum_rs), .max_ed(max_rs),
    .max_a(ma_rs), .max_b(mb_rs));
  approx_mul_err_eval #(.MUL_LAT(0)) u_b0 (.clk(clk), .rst(rst), .start(st_b0),
    .busy(busy_b0), .done(done_b0), .mul_a(a_b0), .mul_b(b_b0), .mul_vld(vld_b0),
    .mul_prod(prod_b0), .err_cnt(err_b0), .sum_ed(sum_b0), .max_ed(max_b0),
    .max_a(ma_b0), .max_b(mb_b0));
  approx_mul_err_eval #(.MUL_LAT(0)) u_z (.clk(clk), .rst(rst), .start(st_z),
    .busy(busy_z), .done(done_z), .mul_a(a_z), .mul_b(b_z), .mul_vld(vld_z),
    .mul_prod(prod_z), .err_cnt(err_z), .sum_ed(sum_z), .max_ed(max_z),
    .max_a(ma_z), .max_b(mb_z));
  approx_mul_err_eval #(.MUL_LAT(2)) u_l2 (.clk(clk), .rst(rst), .start(st_l2),
    .busy(busy_l2), .done(done_l2), .mul_a(a_l2), .mul_b(b_l2), .mul_vld(vld_l2),
    .mul_prod(prod_l2), .err_cnt(err_l2), .sum_ed(sum_l2), .max_ed(max_l2),
    .max_a(ma_l2), .max_b(mb_l2));
  approx_mul_err_eval #(.MUL_LAT(1)) u_rn (.clk(clk), .rst(rst), .start(st_rn),
    .busy(busy_rn), .done(done_rn), .mul_a(a_rn), .mul_b(b_rn), .mul_vld(vld_rn),
    .mul_prod(prod_rn), .err_cnt(err_rn), .sum_ed(sum_rn), .max_ed(max_rn),
    .max_a(ma_rn), .max_b(mb_rn));

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Statistics of the random model, computed directly from the definitions.
  task automatic ref_rn();
    int p, q, ed;
    exp_err = 0; exp_sum = 0; exp_max = 0; exp_ma = 0; exp_mb = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        p  = a * b;
        q  = 32'(approx_rn(a[7:0], b[7:0]));
        ed = (p > q) ? p - q : q - p;
        if (ed != 0) exp_err++;
        exp_sum += longint'(ed);
        if (longint'(ed) > exp_max) begin
          exp_max = longint'(ed); exp_ma = longint'(a); exp_mb = longint'(b);
        end
      end
    end
  endtask

  task automatic proc_z();
    int k;
    st_z = 1'b1; tick(); st_z = 1'b0;
    check_eq("z_first_issue", 40'({vld_z, a_z, b_z}), 40'h10000);
    k = 0;
    while (done_z !== 1'b1 && k < 70000) begin tick(); k++; end
    check_eq("z_done_edge", 40'(k), 40'd65536);
    check_eq("z_busy_end", 40'(busy_z), 40'd0);
    check_eq("z_err_cnt", 40'(err_z), 40'd65025);
    check_eq("z_sum_ed", 40'(sum_z), 40'd1065369600);
    check_eq("z_max_ed", 40'(max_z), 40'd65025);
    check_eq("z_max_a", 40'(ma_z), 40'd255);
    check_eq("z_max_b", 40'(mb_z), 40'd255);
  endtask

  task automatic proc_b0();
    int k;
    st_b0 = 1'b1; tick(); st_b0 = 1'b0;
    k = 0;
    while (done_b0 !== 1'b1 && k < 70000) begin tick(); k++; end
    check_eq("b0_done_edge", 40'(k), 40'd65536);
    check_eq("b0_err_cnt", 40'(err_b0), 40'd16384);
    check_eq("b0_sum_ed", 40'(sum_b0), 40'd16384);
    check_eq("b0_max_ed", 40'(max_b0), 40'd1);
    check_eq("b0_max_a", 40'(ma_b0), 40'd1);
    check_eq("b0_max_b", 40'(mb_b0), 40'd1);
    repeat (3) tick();
    check_eq("b0_hold_err", 40'(err_b0), 40'd16384);
    check_eq("b0_hold_done", 40'({busy_b0, done_b0}), 40'b01);
    b0_exact = 1'b1;
    st_b0 = 1'b1; tick(); st_b0 = 1'b0;
    check_eq("b0_restart_flags", 40'({busy_b0, done_b0}), 40'b10);
    check_eq("b0_restart_clear", 40'({err_b0, sum_b0}) | 40'({max_b0, ma_b0, mb_b0}), 40'd0);
    repeat (2000) tick();
    check_eq("b0_restart_pair", 40'({vld_b0, a_b0, b_b0}), 40'h107D0);
    check_eq("b0_restart_err", 40'(err_b0), 40'd0);
    check_eq("b0_restart_max", 40'({max_b0, sum_b0}), 40'd0);
  endtask

  task automatic proc_l2();
    int k;
    st_l2 = 1'b1; tick(); st_l2 = 1'b0;
    k = 0;
    while (k < 70000) begin
      if (done_l2 === 1'b1) break;
      check_eq("l2_busy", 40'(busy_l2), 40'd1);
      if (k < 65536) check_eq("l2_issue", 40'({vld_l2, a_l2, b_l2}), 40'({1'b1, k[15:0]}));
      else           check_eq("l2_issue_idle", 40'({vld_l2, a_l2, b_l2}), 40'd0);
      tick(); k++;
    end
    check_eq("l2_done_edge", 40'(k), 40'd65538);
    check_eq("l2_busy_end", 40'(busy_l2), 40'd0);
    check_eq("l2_results", 40'({err_l2, sum_l2}) | 40'({max_l2, ma_l2, mb_l2}), 40'd0);
  endtask

  task automatic proc_rn();
    int k;
    repeat ($urandom_range(0, 50)) tick();
    st_rn = 1'b1; tick(); st_rn = 1'b0;
    k = 0;
    while (done_rn !== 1'b1 && k < 70000) begin tick(); k++; end
    check_eq("rn_done_edge", 40'(k), 40'd65537);
    check_eq("rn_err_cnt", 40'(err_rn), 40'(exp_err));
    check_eq("rn_sum_ed", 40'(sum_rn), 40'(exp_sum));
    check_eq("rn_max_ed", 40'(max_rn), 40'(exp_max));
    check_eq("rn_max_a", 40'(ma_rn), 40'(exp_ma));
    check_eq("rn_max_b", 40'(mb_rn), 40'(exp_mb));
  endtask

  task automatic proc_rs();
    int k;
    st_rs = 1'b1; tick(); st_rs = 1'b0;
    repeat (999) tick();
    check_eq("rs_pre_rst_pair", 40'({vld_rs, a_rs, b_rs}), 40'h103E7);
    rs_rst = 1'b1; st_rs = 1'b1; tick(); rs_rst = 1'b0; st_rs = 1'b0;
    check_eq("rs_rst_flags", 40'({busy_rs, done_rs, vld_rs}), 40'd0);
    check_eq("rs_rst_ops", 40'({a_rs, b_rs}), 40'd0);
    check_eq("rs_rst_results", 40'({err_rs, sum_rs}) | 40'({max_rs, ma_rs, mb_rs}), 40'd0);
    tick();
    check_eq("rs_still_idle", 40'({busy_rs, vld_rs}), 40'd0);
    st_rs = 1'b1; tick(); st_rs = 1'b0;
    repeat (499) tick();
    st_rs = 1'b1; tick(); st_rs = 1'b0;
    check_eq("rs_ignored_start", 40'({busy_rs, vld_rs, a_rs, b_rs}), 40'h301F4);
    k = 500;
    while (done_rs !== 1'b1 && k < 70000) begin tick(); k++; end
    check_eq("rs_done_edge", 40'(k), 40'd65536);
    check_eq("rs_results", 40'({err_rs, sum_rs}) | 40'({max_rs, ma_rs, mb_rs}), 40'd0);
  endtask

  initial begin
    rst = 1'b1; rs_rst = 1'b0; b0_exact = 1'b0;
    st_rs = 1'b0; st_b0 = 1'b0; st_z = 1'b0; st_l2 = 1'b0; st_rn = 1'b0;
    rn_am = 8'hFF << $urandom_range(0, 3);
    rn_bm = 8'hFF << $urandom_range(0, 3);
    rn_xm = 8'($urandom_range(0, 15));
    ref_rn();
    repeat (3) tick();
    check_eq("rst_flags", 40'({busy_z, done_z, vld_z}), 40'd0);
    check_eq("rst_ops", 40'({a_z, b_z}), 40'd0);
    check_eq("rst_results", 40'({err_z, sum_z}) | 40'({max_z, ma_z, mb_z}), 40'd0);
    rst = 1'b0;
    fork
      proc_rs();
      proc_b0();
      proc_z();
      proc_l2();
      proc_rn();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
